// File: rtl/wb_spram_slave.sv
// wb_spram_slave: Wishbone slave in front of a single-port, word-addressed RAM.
// Each request is captured in IDLE. It optionally sits in WAIT for ws cycles,
// then passes through RESP. The termination strobe (ACK/ERR/RTY) is registered
// on the edge that leaves RESP, so a request captured at edge n is answered
// from edge n+ws+1 to edge n+ws+2.
//
// Ports:
//   CLK_I, RST_I        clock, synchronous active-high reset
//   CYC_I, STB_I, WE_I  Wishbone cycle / strobe / write enable
//   ADR_I[aw]           byte address; word index is ADR_I[mem_aw+1:2]
//   SEL_I[4], DAT_I     byte lanes and write data
//   TAG_I[4], TAG_O[4]  request tag, echoed with the response
//   DAT_O               read data; holds its value between read ACKs
//   ACK_O/ERR_O/RTY_O   single-cycle, mutually exclusive terminations
module wb_spram_slave #(
  parameter int aw        = 16,
  parameter int dw        = 32,
  parameter int mem_aw    = 10,
  parameter int ws        = 1,
  parameter int rty_every = 0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [aw-1:0] ADR_I,
  input  logic [3:0]    SEL_I,
  input  logic [dw-1:0] DAT_I,
  input  logic [3:0]    TAG_I,
  output logic [dw-1:0] DAT_O,
  output logic          ACK_O,
  output logic          ERR_O,
  output logic          RTY_O,
  output logic [3:0]    TAG_O
);

  localparam int RC_W = (rty_every > 1) ? $clog2(rty_every) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_ACK, K_ERR, K_RTY} kind_t;

  state_t              state, state_n;
  kind_t               kind_q, kind_n;
  logic [3:0]          wcnt;
  logic [RC_W-1:0]     rcnt;
  logic [mem_aw-1:0]   idx_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [dw-1:0]       dat_q;
  logic [3:0]          tag_q;
  logic                oob, rty_hit, req;

  logic [dw-1:0]       mem [2**mem_aw];

  // Byte-offset bits never select anything in a word-addressed RAM.
  logic unused_adr;
  assign unused_adr = ^ADR_I[1:0];

  assign req     = CYC_I && STB_I;
  // Any address bit above the RAM window makes the request out of range.
  assign oob     = |(ADR_I >> (mem_aw + 2));
  assign rty_hit = (rty_every != 0) && (rcnt == RC_W'(rty_every - 1));

  always_comb begin
    kind_n = K_ACK;
    if (oob)          kind_n = K_ERR;
    else if (rty_hit) kind_n = K_RTY;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = (ws == 0) ? RESP : WAIT;
      // Dropping CYC_I while waiting abandons the request silently.
      WAIT:    if (!CYC_I) state_n = IDLE;
               else if (wcnt == '0) state_n = RESP;
      // STB_I seen here is the tail of the request just served, not a new one.
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state  <= IDLE;
      kind_q <= K_ACK;
      wcnt   <= '0;
      rcnt   <= '0;
      idx_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      dat_q  <= '0;
      tag_q  <= '0;
      DAT_O  <= '0;
      TAG_O  <= '0;
      ACK_O  <= 1'b0;
      ERR_O  <= 1'b0;
      RTY_O  <= 1'b0;
    end else begin
      state <= state_n;
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      case (state)
        IDLE: if (req) begin
          idx_q  <= ADR_I[mem_aw+1:2];
          we_q   <= WE_I;
          sel_q  <= SEL_I;
          dat_q  <= DAT_I;
          tag_q  <= TAG_I;
          kind_q <= kind_n;
          wcnt   <= 4'(ws - 1);
          // ERR captures do not consume a slot of the retry period.
          if (!oob && rty_every != 0)
            rcnt <= rty_hit ? '0 : rcnt + 1'b1;
        end
        WAIT: if (wcnt != '0) wcnt <= wcnt - 1'b1;
        RESP: begin
          TAG_O <= tag_q;
          case (kind_q)
            K_ACK: begin
              ACK_O <= 1'b1;
              if (!we_q) DAT_O <= mem[idx_q];
            end
            K_ERR:   ERR_O <= 1'b1;
            K_RTY:   RTY_O <= 1'b1;
            default: ERR_O <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // RAM contents survive reset; only an ACKed write in RESP touches them.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && state == RESP && kind_q == K_ACK && we_q) begin
      for (int i = 0; i < 4; i++)
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= dat_q[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_wb_spram_slave.sv
// Bench for wb_spram_slave. Three instances with different wait-state and
// retry settings share one clock. Directed requests push the hand-computed
// response into a per-instance queue. A negedge monitor pops and compares
// kind, tag, read data and arrival edge whenever a strobe shows up.
module tb_wb_spram_slave;

  typedef struct {
    logic [1:0]  kind;   // 0 ACK, 1 ERR, 2 RTY
    logic [3:0]  tag;
    logic        chk;    // compare DAT_O
    logic [31:0] dat;
    int          at;     // edge count at which the strobe is expected
  } exp_t;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        cyc  [3];
  logic        stb  [3];
  logic        we   [3];
  logic [15:0] adr  [3];
  logic [3:0]  sel  [3];
  logic [31:0] dati [3];
  logic [3:0]  tagi [3];
  logic [31:0] dato [3];
  logic        ack  [3];
  logic        err  [3];
  logic        rty  [3];
  logic [3:0]  tago [3];

  exp_t q0[$], q1[$], q2[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_spram_slave #(
      .aw(16), .dw(32), .mem_aw(10),
      .ws(g == 0 ? 1 : (g == 1 ? 4 : 3)),
      .rty_every(g == 2 ? 3 : 0)
    ) u_dut (
      .CLK_I(clk), .RST_I(rst[g]), .CYC_I(cyc[g]), .STB_I(stb[g]),
      .WE_I(we[g]), .ADR_I(adr[g]), .SEL_I(sel[g]), .DAT_I(dati[g]),
      .TAG_I(tagi[g]), .DAT_O(dato[g]), .ACK_O(ack[g]), .ERR_O(err[g]),
      .RTY_O(rty[g]), .TAG_O(tago[g])
    );
  end

  function automatic int ws_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 3);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] || err[d] || rty[d]) begin
        exp_t e;
        logic have;
        logic [1:0] got;
        have = 1'b0;
        got  = (ack[d] && !err[d] && !rty[d]) ? 2'd0 :
               (err[d] && !ack[d] && !rty[d]) ? 2'd1 :
               (rty[d] && !ack[d] && !err[d]) ? 2'd2 : 2'd3;
        case (d)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL dut%0d unexpected strobe kind=%0d tag=%h at edge %0d", d, got, tago[d], edge_n);
        end else if (got != e.kind || tago[d] != e.tag || edge_n != e.at ||
                     (e.chk && dato[d] !== e.dat)) begin
          errors++;
          $display("FAIL dut%0d resp tag%h: got kind=%0d tag=%h dat=%h edge=%0d, want kind=%0d tag=%h dat=%h(chk=%0d) edge=%0d",
                   d, e.tag, got, tago[d], dato[d], edge_n, e.kind, e.tag, e.dat, e.chk, e.at);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input int d, input bit w, input logic [15:0] a,
                       input logic [3:0] s, input logic [31:0] v, input logic [3:0] t);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; dati[d] = v; tagi[d] = t;
  endtask

  task automatic idle(input int d);
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
  endtask

  // Entered #1 after a posedge. STB stays high through the response edge,
  // as a real master would, and the next call issues at minimum spacing.
  task automatic xfer(input int d, input bit w, input logic [15:0] a,
                      input logic [3:0] s, input logic [31:0] v, input logic [3:0] t,
                      input logic [1:0] k, input bit c, input logic [31:0] ed);
    exp_t e;
    e.kind = k; e.tag = t; e.chk = c; e.dat = ed;
    e.at   = edge_n + ws_of(d) + 2;
    push(d, e);
    drive(d, w, a, s, v, t);
    @(posedge clk);
    repeat (ws_of(d) + 1) @(posedge clk);
    #1 idle(d);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; idle(d);
      adr[d] = '0; sel[d] = '0; dati[d] = '0; tagi[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outputs_dut%0d", d),
          {25'd0, ack[d], err[d], rty[d], tago[d], dato[d]}, 64'd0);
    @(posedge clk);
    #1;

    // dut0: ws=1, no retries
    xfer(0, 1, 16'h0010, 4'hF, 32'hDEADBEEF, 4'h3, 2'd0, 0, 32'h0);
    xfer(0, 0, 16'h0010, 4'hF, 32'h0,        4'h5, 2'd0, 1, 32'hDEADBEEF);
    xfer(0, 1, 16'h0020, 4'hF, 32'hFFFFFFFF, 4'h1, 2'd0, 0, 32'h0);
    xfer(0, 1, 16'h0020, 4'h5, 32'h11223344, 4'h2, 2'd0, 0, 32'h0);
    xfer(0, 0, 16'h0020, 4'hF, 32'h0,        4'h4, 2'd0, 1, 32'hFF22FF44);
    xfer(0, 1, 16'h0020, 4'h0, 32'h00000000, 4'h6, 2'd0, 0, 32'h0);
    xfer(0, 0, 16'h0023, 4'h0, 32'h0,        4'h7, 2'd0, 1, 32'hFF22FF44);
    xfer(0, 0, 16'h1000, 4'hF, 32'h0,        4'h8, 2'd1, 1, 32'hFF22FF44);
    xfer(0, 1, 16'h8010, 4'hF, 32'h00000000, 4'h9, 2'd1, 1, 32'hFF22FF44);
    xfer(0, 0, 16'h0010, 4'hF, 32'h0,        4'hA, 2'd0, 1, 32'hDEADBEEF);
    xfer(0, 0, 16'h0010, 4'hF, 32'h0,        4'hB, 2'd0, 1, 32'hDEADBEEF);
    xfer(0, 1, 16'h0010, 4'hF, 32'h0BADF00D, 4'hC, 2'd0, 0, 32'h0);
    xfer(0, 0, 16'h0010, 4'hF, 32'h0,        4'hD, 2'd0, 1, 32'h0BADF00D);
    xfer(0, 1, 16'h0FFC, 4'hF, 32'h5A5A5A5A, 4'hE, 2'd0, 0, 32'h0);
    xfer(0, 0, 16'h0FFC, 4'hF, 32'h0,        4'hF, 2'd0, 1, 32'h5A5A5A5A);

    // dut1: ws=4, write then an aborted overwrite
    xfer(1, 1, 16'h0030, 4'hF, 32'hCAFEF00D, 4'h1, 2'd0, 0, 32'h0);
    xfer(1, 0, 16'h0030, 4'hF, 32'h0,        4'h2, 2'd0, 1, 32'hCAFEF00D);
    drive(1, 1, 16'h0030, 4'hF, 32'h12345678, 4'hA);
    @(posedge clk); #1 stb[1] = 1'b0;
    @(posedge clk); #1 idle(1);
    idle_cycles(10);
    xfer(1, 0, 16'h0030, 4'hF, 32'h0,        4'h3, 2'd0, 1, 32'hCAFEF00D);

    // dut2: ws=3, retry every 3rd non-ERR request
    xfer(2, 1, 16'h0040, 4'hF, 32'hAAAA0001, 4'h1, 2'd0, 0, 32'h0);
    xfer(2, 1, 16'h0044, 4'hF, 32'hBBBB0002, 4'h2, 2'd0, 0, 32'h0);
    xfer(2, 1, 16'h0040, 4'hF, 32'hCCCC0003, 4'h3, 2'd2, 1, 32'h0);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'h4, 2'd0, 1, 32'hAAAA0001);
    xfer(2, 0, 16'h0044, 4'hF, 32'h0,        4'h5, 2'd0, 1, 32'hBBBB0002);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'h6, 2'd2, 1, 32'hBBBB0002);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'h7, 2'd0, 1, 32'hAAAA0001);
    xfer(2, 0, 16'h0044, 4'hF, 32'h0,        4'h8, 2'd0, 1, 32'hBBBB0002);
    xfer(2, 0, 16'h0044, 4'hF, 32'h0,        4'h9, 2'd2, 1, 32'hBBBB0002);
    // ERR must not advance the retry period
    xfer(2, 0, 16'h1000, 4'hF, 32'h0,        4'hA, 2'd1, 1, 32'hBBBB0002);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'hB, 2'd0, 1, 32'hAAAA0001);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'hC, 2'd0, 1, 32'hAAAA0001);
    xfer(2, 0, 16'h0040, 4'hF, 32'h0,        4'hD, 2'd2, 1, 32'hAAAA0001);

    // dut2: reset pulsed two edges into WAIT
    drive(2, 1, 16'h0044, 4'hF, 32'h99999999, 4'hE);
    @(posedge clk); #1 stb[2] = 1'b0;
    @(posedge clk); #1 rst[2] = 1'b1;
    @(posedge clk); #1 rst[2] = 1'b0; idle(2);
    @(negedge clk);
    chk("reset_midwait_outputs",
        {25'd0, ack[2], err[2], rty[2], tago[2], dato[2]}, 64'd0);
    idle_cycles(6);
    xfer(2, 0, 16'h0044, 4'hF, 32'h0,        4'h1, 2'd0, 1, 32'hBBBB0002);

    idle_cycles(10);
    chk("dut0_pending", 64'(q0.size()), 64'd0);
    chk("dut1_pending", 64'(q1.size()), 64'd0);
    chk("dut2_pending", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
